// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the single-port memory arbiter between fetch (I) and load/store (D).
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    localparam int          ADDR_W     = 32;
    localparam int          DATA_W     = 32;
    localparam logic [1:0]  WIDTH_WORD = 2'b10;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and bus-side signals of the memory port arbiter; slave = arbiter, master = environment.
interface mem_port_arbiter_if;
    import mem_port_arbiter_pkg::*;

    logic              i_req_i;
    logic [ADDR_W-1:0] i_addr_i;
    logic              i_gnt_o;
    logic              i_rvalid_o;
    logic [DATA_W-1:0] i_rdata_o;

    logic              d_req_i;
    logic [ADDR_W-1:0] d_addr_i;
    logic [DATA_W-1:0] d_wdata_i;
    logic              d_we_i;
    logic [1:0]        d_width_i;
    logic              d_gnt_o;
    logic              d_rvalid_o;
    logic [DATA_W-1:0] d_rdata_o;

    logic              flush_i;

    logic              m_req_o;
    logic [ADDR_W-1:0] m_addr_o;
    logic [DATA_W-1:0] m_wdata_o;
    logic              m_we_o;
    logic [1:0]        m_width_o;
    logic              m_gnt_i;
    logic              m_rvalid_i;
    logic [DATA_W-1:0] m_rdata_i;

    modport slave (
        input  i_req_i, i_addr_i,
        output i_gnt_o, i_rvalid_o, i_rdata_o,
        input  d_req_i, d_addr_i, d_wdata_i, d_we_i, d_width_i,
        output d_gnt_o, d_rvalid_o, d_rdata_o,
        input  flush_i,
        output m_req_o, m_addr_o, m_wdata_o, m_we_o, m_width_o,
        input  m_gnt_i, m_rvalid_i, m_rdata_i
    );

    modport master (
        output i_req_i, i_addr_i,
        input  i_gnt_o, i_rvalid_o, i_rdata_o,
        output d_req_i, d_addr_i, d_wdata_i, d_we_i, d_width_i,
        input  d_gnt_o, d_rvalid_o, d_rdata_o,
        output flush_i,
        input  m_req_o, m_addr_o, m_wdata_o, m_we_o, m_width_o,
        output m_gnt_i, m_rvalid_i, m_rdata_i
    );

endinterface

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of arbitrations a pending fetch has lost; force_fetch makes fetch win the next one.
module mem_arb_starve_ctr #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             force_fetch
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != LIMIT)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign force_fetch = (cnt == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding memory port shared by fetch and load/store; D wins unless fetch has starved.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  port
);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic              discard_q, discard_d;
    logic              m_req_q, m_req_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic              m_we_q, m_we_d;
    logic [1:0]        m_width_q, m_width_d;

    logic              i_gnt, d_gnt, i_rvalid, d_rvalid;
    logic              ctr_inc, ctr_clr;
    logic              force_fetch;
    logic              i_win;
    logic              flush_fetch;
    logic [CNT_W-1:0]  starve_cnt;

    mem_arb_starve_ctr #(
        .STARVE_LIMIT(STARVE_LIMIT),
        .CNT_W       (CNT_W)
    ) u_starve_ctr (
        .clk        (clk),
        .rst        (rst),
        .inc        (ctr_inc),
        .clr        (ctr_clr),
        .cnt        (starve_cnt),
        .force_fetch(force_fetch)
    );

    assign i_win       = port.i_req_i && (!port.d_req_i || force_fetch);
    assign flush_fetch = port.flush_i && (owner_q == OWN_I);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_I;
            discard_q <= 1'b0;
            m_req_q   <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_we_q    <= 1'b0;
            m_width_q <= 2'b00;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            discard_q <= discard_d;
            m_req_q   <= m_req_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            m_we_q    <= m_we_d;
            m_width_q <= m_width_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        discard_d = discard_q;
        m_req_d   = m_req_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        m_we_d    = m_we_q;
        m_width_d = m_width_q;
        i_gnt     = 1'b0;
        d_gnt     = 1'b0;
        i_rvalid  = 1'b0;
        d_rvalid  = 1'b0;
        ctr_inc   = 1'b0;
        ctr_clr   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (port.i_req_i || port.d_req_i) begin
                    state_d = ST_REQ;
                    m_req_d = 1'b1;
                    if (i_win) begin
                        owner_d   = OWN_I;
                        m_addr_d  = port.i_addr_i;
                        m_wdata_d = '0;
                        m_we_d    = 1'b0;
                        m_width_d = WIDTH_WORD;
                        ctr_clr   = 1'b1;
                    end else begin
                        owner_d   = OWN_D;
                        m_addr_d  = port.d_addr_i;
                        m_wdata_d = port.d_wdata_i;
                        m_we_d    = port.d_we_i;
                        m_width_d = port.d_width_i;
                        // D only loses to nobody here, so a pending fetch just lost a round
                        ctr_inc   = port.i_req_i;
                    end
                end
            end
            ST_REQ: begin
                if (flush_fetch) discard_d = 1'b1;
                if (port.m_gnt_i) begin
                    i_gnt   = (owner_q == OWN_I);
                    d_gnt   = (owner_q == OWN_D);
                    m_req_d = 1'b0;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (flush_fetch) discard_d = 1'b1;
                if (port.m_rvalid_i) begin
                    // a flush arriving with the response itself must also suppress it
                    i_rvalid  = (owner_q == OWN_I) && !discard_q && !port.flush_i;
                    d_rvalid  = (owner_q == OWN_D);
                    discard_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign port.i_gnt_o    = i_gnt;
    assign port.d_gnt_o    = d_gnt;
    assign port.i_rvalid_o = i_rvalid;
    assign port.d_rvalid_o = d_rvalid;
    assign port.i_rdata_o  = port.m_rdata_i;
    assign port.d_rdata_o  = port.m_rdata_i;
    assign port.m_req_o    = m_req_q;
    assign port.m_addr_o   = m_addr_q;
    assign port.m_wdata_o  = m_wdata_q;
    assign port.m_we_o     = m_we_q;
    assign port.m_width_o  = m_width_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed per-cycle vector table plus hand sequences for starvation and asynchronous reset.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if bus_if ();

    mem_port_arbiter #(
        .STARVE_LIMIT(4),
        .CNT_W       (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .port(bus_if.slave)
    );

    typedef struct {
        logic        i_req;
        logic [31:0] i_addr;
        logic        d_req;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        d_we;
        logic [1:0]  d_width;
        logic        flush;
        logic        m_gnt;
        logic        m_rvalid;
        logic [31:0] m_rdata;
        logic        e_mreq;
        logic        chk_m;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_we;
        logic [1:0]  e_width;
        logic        e_ignt;
        logic        e_irv;
        logic        e_dgnt;
        logic        e_drv;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus_if.i_req_i    = v.i_req;
        bus_if.i_addr_i   = v.i_addr;
        bus_if.d_req_i    = v.d_req;
        bus_if.d_addr_i   = v.d_addr;
        bus_if.d_wdata_i  = v.d_wdata;
        bus_if.d_we_i     = v.d_we;
        bus_if.d_width_i  = v.d_width;
        bus_if.flush_i    = v.flush;
        bus_if.m_gnt_i    = v.m_gnt;
        bus_if.m_rvalid_i = v.m_rvalid;
        bus_if.m_rdata_i  = v.m_rdata;
    endtask

    initial begin
        logic exp_is_i[5];
        logic [2:0] exp_cnt[5];
        int grants;

        // i_req i_addr d_req d_addr d_wdata we wid fl gnt rv rdata | mreq chk addr wdata we wid igt irv dgt drv rdata
        // fetch alone
        vecs.push_back('{1, 32'h100, 0, 0, 0, 0, 0, 0, 1, 0, 0,           0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{1, 32'h100, 0, 0, 0, 0, 0, 0, 1, 0, 0,           1, 1, 32'h100, 0, 0, 2, 1, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h13,            0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h13});
        vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,                 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        // simultaneous: D first, then I
        vecs.push_back('{1, 32'h200, 1, 32'h8000, 0, 0, 2, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{1, 32'h200, 1, 32'h8000, 0, 0, 2, 0, 1, 0, 0,    1, 1, 32'h8000, 0, 0, 2, 0, 0, 1, 0, 0});
        vecs.push_back('{1, 32'h200, 0, 0, 0, 0, 0, 0, 0, 1, 32'h55,      0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h55});
        vecs.push_back('{1, 32'h200, 0, 0, 0, 0, 0, 0, 0, 0, 0,           0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{1, 32'h200, 0, 0, 0, 0, 0, 0, 1, 0, 0,           1, 1, 32'h200, 0, 0, 2, 1, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h66,            0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h66});
        vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,                 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        // flush in RESP discards, next fetch returns normally
        vecs.push_back('{1, 32'h300, 0, 0, 0, 0, 0, 0, 1, 0, 0,           0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{1, 32'h300, 0, 0, 0, 0, 0, 0, 1, 0, 0,           1, 1, 32'h300, 0, 0, 2, 1, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,                 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF,      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{1, 32'h400, 0, 0, 0, 0, 0, 0, 1, 0, 0,           0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{1, 32'h400, 0, 0, 0, 0, 0, 0, 1, 0, 0,           1, 1, 32'h400, 0, 0, 2, 1, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h93,            0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h93});
        // flush together with rvalid suppresses
        vecs.push_back('{1, 32'h500, 0, 0, 0, 0, 0, 0, 1, 0, 0,           0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{1, 32'h500, 0, 0, 0, 0, 0, 0, 1, 0, 0,           1, 1, 32'h500, 0, 0, 2, 1, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 32'h77,            0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        // flush ignored in IDLE and on D transactions
        vecs.push_back('{0, 0, 1, 32'h20, 0, 0, 2, 1, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 1, 32'h20, 0, 0, 2, 0, 1, 0, 0,            1, 1, 32'h20, 0, 0, 2, 0, 0, 1, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 32'h88,            0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h88});
        vecs.push_back('{1, 32'h600, 0, 0, 0, 0, 0, 1, 0, 0, 0,           0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{1, 32'h600, 0, 0, 0, 0, 0, 0, 1, 0, 0,           1, 1, 32'h600, 0, 0, 2, 1, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h99,            0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h99});
        // store with a stalled bus grant
        vecs.push_back('{0, 0, 1, 32'h10, 32'hA5A5A5A5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 1, 32'h10, 32'hA5A5A5A5, 1, 0, 0, 0, 0, 0, 1, 1, 32'h10, 32'hA5A5A5A5, 1, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 1, 32'h10, 32'hA5A5A5A5, 1, 0, 0, 1, 0, 0, 1, 1, 32'h10, 32'hA5A5A5A5, 1, 0, 0, 0, 1, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,                 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,                 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0});
        // rvalid in IDLE is ignored
        vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h12345678,      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,                 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});

        drive('{default: '0});
        @(negedge clk);
        #1;
        chk("reset_m_req", bus_if.m_req_o, 0);
        chk("reset_m_addr", bus_if.m_addr_o, 0);
        chk("reset_m_we", bus_if.m_we_o, 0);
        chk("reset_m_width", bus_if.m_width_o, 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            chk($sformatf("v%0d_m_req", i), bus_if.m_req_o, vecs[i].e_mreq);
            if (vecs[i].chk_m) begin
                chk($sformatf("v%0d_m_addr", i), bus_if.m_addr_o, vecs[i].e_addr);
                chk($sformatf("v%0d_m_we", i), bus_if.m_we_o, vecs[i].e_we);
                chk($sformatf("v%0d_m_width", i), bus_if.m_width_o, vecs[i].e_width);
                if (vecs[i].e_we || i == 0)
                    chk($sformatf("v%0d_m_wdata", i), bus_if.m_wdata_o, vecs[i].e_wdata);
            end
            chk($sformatf("v%0d_i_gnt", i), bus_if.i_gnt_o, vecs[i].e_ignt);
            chk($sformatf("v%0d_i_rvalid", i), bus_if.i_rvalid_o, vecs[i].e_irv);
            chk($sformatf("v%0d_d_gnt", i), bus_if.d_gnt_o, vecs[i].e_dgnt);
            chk($sformatf("v%0d_d_rvalid", i), bus_if.d_rvalid_o, vecs[i].e_drv);
            if (vecs[i].e_irv) chk($sformatf("v%0d_i_rdata", i), bus_if.i_rdata_o, vecs[i].e_rdata);
            if (vecs[i].e_drv) chk($sformatf("v%0d_d_rdata", i), bus_if.d_rdata_o, vecs[i].e_rdata);
        end

        // Starvation: both requesters held, bus always ready -> D,D,D,D then I
        exp_is_i = '{0, 0, 0, 0, 1};
        exp_cnt  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
        grants   = 0;
        @(negedge clk);
        drive('{i_req: 1, i_addr: 32'h700, d_req: 1, d_addr: 32'h9000, d_width: 2'b10,
                m_gnt: 1, m_rvalid: 1, default: '0});
        for (int cyc = 0; cyc < 60; cyc++) begin
            #1;
            if (bus_if.i_gnt_o || bus_if.d_gnt_o) begin
                chk($sformatf("starve_owner%0d", grants), bus_if.i_gnt_o, exp_is_i[grants]);
                chk($sformatf("starve_cnt%0d", grants), dut.starve_cnt, exp_cnt[grants]);
                if (bus_if.i_gnt_o) chk("starve_i_addr", bus_if.m_addr_o, 32'h700);
                grants++;
            end
            if (grants == 5) break;
            @(negedge clk);
        end
        chk("starve_grants", grants, 5);
        @(negedge clk);
        bus_if.i_req_i = 1'b0;
        bus_if.d_req_i = 1'b0;
        @(negedge clk);
        bus_if.m_rvalid_i = 1'b0;
        bus_if.m_gnt_i    = 1'b0;
        @(negedge clk);

        // Reset in REQ with the bus never granting
        drive('{i_req: 1, i_addr: 32'hA00, default: '0});
        @(negedge clk);
        #1;
        chk("rst_pre_m_req", bus_if.m_req_o, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_async_m_req", bus_if.m_req_o, 0);
        chk("rst_async_m_addr", bus_if.m_addr_o, 0);
        @(negedge clk);
        rst = 1'b0;
        bus_if.i_req_i = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_idle_m_req", bus_if.m_req_o, 0);
        drive('{i_req: 1, i_addr: 32'hB00, m_gnt: 1, default: '0});
        @(negedge clk);
        #1;
        chk("rst_new_m_req", bus_if.m_req_o, 1);
        chk("rst_new_m_addr", bus_if.m_addr_o, 32'hB00);
        chk("rst_new_i_gnt", bus_if.i_gnt_o, 1);
        @(negedge clk);
        drive('{m_rvalid: 1, m_rdata: 32'h00C0FFEE, default: '0});
        #1;
        chk("rst_new_i_rvalid", bus_if.i_rvalid_o, 1);
        chk("rst_new_i_rdata", bus_if.i_rdata_o, 32'h00C0FFEE);
        @(negedge clk);
        bus_if.m_rvalid_i = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single external memory port between instruction fetch (I side) and the execute stage's load/store port (D side).
- Exactly one outstanding bus transaction at a time.
- D side wins by default, since it belongs to the older instruction; a starvation counter guarantees fetch progress.
- flush_i (taken jump) discards the response of an in-flight fetch so it never reaches the pipeline.

Parameters:
STARVE_LIMIT, 4, consecutive losing cycles after which a pending fetch wins the next arbitration (>=1)
CNT_W, 3, width of starvation counter; must hold STARVE_LIMIT

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
i_req_i  in  1  fetch request; held with i_addr_i until i_gnt_o
i_addr_i  in  32  fetch address
i_gnt_o  out  1  fetch accepted by bus (1-cycle pulse)
i_rvalid_o  out  1  fetch data valid (1-cycle pulse)
i_rdata_o  out  32  fetch data
d_req_i  in  1  data request; held with attributes until d_gnt_o
d_addr_i  in  32  data address
d_wdata_i  in  32  store data
d_we_i  in  1  1=store, 0=load
d_width_i  in  2  access width code (funct3[1:0])
d_gnt_o  out  1  data accepted by bus (1-cycle pulse)
d_rvalid_o  out  1  load data / store completion (1-cycle pulse)
d_rdata_o  out  32  load data
flush_i  in  1  discard in-flight fetch response
m_req_o  out  1  bus request, registered
m_addr_o  out  32  bus address, registered
m_wdata_o  out  32  bus write data, registered
m_we_o  out  1  bus write enable, registered (0 for fetch)
m_width_o  out  2  bus width, registered (2'b10 for fetch)
m_gnt_i  in  1  bus accepts request while m_req_o=1
m_rvalid_i  in  1  bus response, one per accepted request (stores included)
m_rdata_i  in  32  bus read data

Behaviour:
- Reset: state IDLE, owner=I, discard=0, starve_cnt=0. All m_* outputs 0. All gnt/rvalid outputs 0. rdata outputs follow m_rdata_i and are don't-care while their rvalid is 0.
- FSM, states IDLE / REQ / RESP:
  - IDLE: if any request is pending, pick the winner, latch its attributes into m_*, set m_req_o<=1, owner<=winner, and go to REQ. No request: stay in IDLE.
  - REQ: m_req_o and attributes stay held. On m_gnt_i: pulse the owner's gnt_o combinationally in that same cycle, set m_req_o<=0, go to RESP.
  - RESP: on m_rvalid_i: pass m_rdata_i combinationally to the owner's rdata, pulse the owner's rvalid (unless suppressed by discard), then go to IDLE and clear discard.
- Arbitration (IDLE only):
  - D wins if d_req_i, unless starve_cnt==STARVE_LIMIT and i_req_i, in which case I wins.
  - Otherwise I wins if i_req_i.
- Starvation counter:
  - Increments, saturating at STARVE_LIMIT, each IDLE cycle in which i_req_i=1 and D wins.
  - Clears to 0 when I wins.
  - Holds otherwise.
- Latency: request seen in IDLE at cycle 0 -> m_req_o=1 at cycle 1. With bus gnt at cycle 1 and rvalid at cycle 2, the next m_req_o can assert at cycle 4.
- flush_i:
  - If owner==I and state is REQ or RESP, set discard. The bus handshake still completes (a request is never withdrawn), but i_rvalid_o stays 0 for that response.
  - flush_i in the same cycle as m_rvalid_i also suppresses.
  - flush_i has no effect in IDLE or on D transactions.
  - After flush, the fetch unit re-requests with its new address.
- i_gnt_o/d_gnt_o are 0 outside REQ. m_rvalid_i outside RESP is ignored and never forwarded.
- Requesters must hold req and attributes until gnt. The arbiter samples attributes only at the IDLE grant.
- Reset mid-transaction: m_req_o drops immediately (asynchronous) and the FSM returns to IDLE. The bus controller is reset by the same rst.

Decomposition:
- Shared package/include: state encodings (ST_IDLE, ST_REQ, ST_RESP), owner encodings (OWN_I, OWN_D), fetch width constant WIDTH_WORD=2'b10.
- One natural sub-module: mem_arb_starve_ctr (saturating counter plus force-fetch flag).

Test Plan:
- Fetch alone: i_req_i=1, i_addr_i=0x100, m_gnt_i tied 1, rvalid 1 cycle after gnt with rdata=0x00000013 -> m_req_o at cycle 1 with m_addr_o=0x100, m_we_o=0, m_width_o=2'b10; i_gnt_o at cycle 1; i_rvalid_o with 0x13 at cycle 2.
- Simultaneous: i_req (0x200) and d_req (load 0x8000) in the same cycle -> D is issued first; I is issued next at 0x200; starve_cnt=1 before I wins, 0 after.
- Starvation: d_req held continuously, i_req held, STARVE_LIMIT=4 -> 4 D transactions, then I wins the 5th arbitration.
- Flush: fetch 0x300 granted, flush_i pulsed in RESP, rvalid rdata=0xDEADBEEF -> i_rvalid_o stays 0; a subsequent fetch 0x400 returns normally with i_rvalid_o=1.
- Store: d_req, d_we=1, d_addr=0x10, d_wdata=0xA5A5A5A5, width=2'b00 -> m_* carry those values; d_rvalid_o pulses on the bus rvalid.
- Reset mid-REQ with m_gnt_i held 0: assert rst -> m_req_o=0 immediately; after release, FSM is IDLE and a new request issues normally.
